mac_operand_sequencer: RTL and testbench



---
 rtl/mac_pkg.sv | 32 +++
 rtl/mac_operand_bank.sv | 74 +++++++
 rtl/mac_operand_sequencer.sv | 169 ++++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC operand sequencer and its operand bank.
//   MAC_DATA_W / MAC_ACC_W : default operand / accumulator widths
//   seq_state_t            : sequencer FSM states
//   op_pair_t              : one (x, w) operand pair at default width
//   addr_w()               : index width for an N-entry table (never below 1)
// -----------------------------------------------------------------------------
package mac_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_ACC_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    GAP   = 3'd2,
    FEED  = 3'd3,
    WAIT  = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [MAC_DATA_W-1:0] x;
    logic [MAC_DATA_W-1:0] w;
  } op_pair_t;

  // $clog2(1) is 0; a 1-entry bank still needs a 1-bit address.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_operand_bank.sv
// -----------------------------------------------------------------------------
// mac_operand_bank
// N_TAPS-entry register file of signed (x, w) operand pairs.
//   clk, rst         : clock, asynchronous active-high clear of every entry
//   wr_en, wr_addr   : synchronous write strobe and entry index
//   wr_x, wr_w       : operand pair to store
//   rd_addr          : combinational read index
//   rd_x, rd_w       : pair at rd_addr (0 for an index with no entry)
// Writes to an index >= N_TAPS match no entry and are dropped.
// -----------------------------------------------------------------------------
module mac_operand_bank
  import mac_pkg::*;
#(
  parameter int N_TAPS = 3,
  parameter int DATA_W = MAC_DATA_W,
  parameter int ADDR_W = addr_w(N_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_x,
  input  logic [DATA_W-1:0] wr_w,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_x,
  output logic [DATA_W-1:0] rd_w
);

  logic [N_TAPS-1:0][DATA_W-1:0] x_all;
  logic [N_TAPS-1:0][DATA_W-1:0] w_all;

  generate
    for (genvar i = 0; i < N_TAPS; i++) begin : g_ent
      logic [DATA_W-1:0] x_q, x_d;
      logic [DATA_W-1:0] w_q, w_d;

      always_comb begin
        x_d = x_q;
        w_d = w_q;
        if (wr_en && (wr_addr == ADDR_W'(i))) begin
          x_d = wr_x;
          w_d = wr_w;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_q <= '0;
          w_q <= '0;
        end else begin
          x_q <= x_d;
          w_q <= w_d;
        end
      end

      assign x_all[i] = x_q;
      assign w_all[i] = w_q;
    end
  endgenerate

  // Mux by compare rather than direct index so a non-power-of-two bank
  // never reads past its last entry.
  always_comb begin
    rd_x = '0;
    rd_w = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_x = x_all[i];
        rd_w = w_all[i];
      end
    end
  end

endmodule

// File: rtl/mac_operand_sequencer.sv
// -----------------------------------------------------------------------------
// mac_operand_sequencer
// Host-side driver for one MAC neuron. Holds an operand bank, and on go it
// pulses n_start, idles one arm cycle, streams the N_TAPS pairs one per
// cycle, then waits up to TIMEOUT cycles for n_done and returns n_acc.
//   clk, rst                 : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_x/wr_w  : bank write port (IDLE only)
//   go                       : start one evaluation (IDLE only)
//   busy                     : high in any non-IDLE state
//   result, result_valid     : captured n_acc and its one-cycle strobe
//   timeout_err              : sticky, set when WAIT expires, cleared by go
//   n_start, n_x, n_w        : neuron start pulse and operand stream
//   n_done, n_acc            : neuron completion and accumulator
// All outputs are registered: each _d is computed from the next state so the
// output lines up with the cycle that state is occupied.
// -----------------------------------------------------------------------------
module mac_operand_sequencer
  import mac_pkg::*;
#(
  parameter int  N_TAPS  = 3,
  parameter int  DATA_W  = MAC_DATA_W,
  parameter int  ACC_W   = MAC_ACC_W,
  parameter int  TIMEOUT = 16,
  localparam int ADDR_W  = addr_w(N_TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_x,
  input  logic [DATA_W-1:0] wr_w,
  input  logic              go,
  output logic              busy,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  output logic              timeout_err,
  output logic              n_start,
  output logic [DATA_W-1:0] n_x,
  output logic [DATA_W-1:0] n_w,
  input  logic              n_done,
  input  logic [ACC_W-1:0]  n_acc
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] TAP_LAST  = ADDR_W'(N_TAPS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] tap_q, tap_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              busy_q, busy_d;
  logic              n_start_q, n_start_d;
  logic [DATA_W-1:0] n_x_q, n_x_d;
  logic [DATA_W-1:0] n_w_q, n_w_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              timeout_err_q, timeout_err_d;

  logic              bank_wr_en;
  logic [DATA_W-1:0] rd_x, rd_w;

  // Host writes only land while idle; a write in the go cycle commits on
  // the same edge and is long settled by the time GAP reads entry 0.
  assign bank_wr_en = wr_en && (state_q == IDLE);

  // Read index is the next tap so the pair can be registered into n_x/n_w
  // for the cycle that tap is driven.
  mac_operand_bank #(
    .N_TAPS (N_TAPS),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_wr_en),
    .wr_addr (wr_addr),
    .wr_x    (wr_x),
    .wr_w    (wr_w),
    .rd_addr (tap_d),
    .rd_x    (rd_x),
    .rd_w    (rd_w)
  );

  always_comb begin
    state_d        = state_q;
    tap_d          = tap_q;
    wait_d         = wait_q;
    n_start_d      = 1'b0;
    result_d       = result_q;
    result_valid_d = 1'b0;
    timeout_err_d  = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d       = START;
          n_start_d     = 1'b1;
          timeout_err_d = 1'b0;
        end
      end
      START: state_d = GAP;
      GAP: begin
        state_d = FEED;
        tap_d   = '0;
      end
      FEED: begin
        if (tap_q == TAP_LAST) begin
          state_d = WAIT;
          wait_d  = '0;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      WAIT: begin
        // A completion on the last permitted cycle still wins over timeout.
        if (n_done) begin
          state_d        = IDLE;
          result_d       = n_acc;
          result_valid_d = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    n_x_d  = (state_d == FEED) ? rd_x : '0;
    n_w_d  = (state_d == FEED) ? rd_w : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      tap_q          <= '0;
      wait_q         <= '0;
      busy_q         <= 1'b0;
      n_start_q      <= 1'b0;
      n_x_q          <= '0;
      n_w_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      tap_q          <= tap_d;
      wait_q         <= wait_d;
      busy_q         <= busy_d;
      n_start_q      <= n_start_d;
      n_x_q          <= n_x_d;
      n_w_q          <= n_w_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign busy         = busy_q;
  assign n_start      = n_start_q;
  assign n_x          = n_x_q;
  assign n_w          = n_w_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_operand_sequencer
// Bench for mac_operand_sequencer. A behavioural neuron stub accumulates the
// streamed taps and answers with n_done after a chosen delay; the expected
// result comes from a model bank and a plain sum of products.
// -----------------------------------------------------------------------------
module tb_mac_operand_sequencer;
  import mac_pkg::*;

  localparam int N_TAPS  = 3;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 16;
  localparam int TIMEOUT = 16;
  localparam int ADDR_W  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_x = '0, wr_w = '0;
  logic              go = 1'b0;
  logic              busy, result_valid, timeout_err, n_start;
  logic [ACC_W-1:0]  result;
  logic [DATA_W-1:0] n_x, n_w;
  logic              n_done = 1'b0;
  logic [ACC_W-1:0]  n_acc = '0;

  int checks = 0;
  int failures = 0;

  op_pair_t mbank [N_TAPS];

  always #5 clk = ~clk;

  mac_operand_sequencer #(
    .N_TAPS (N_TAPS), .DATA_W (DATA_W), .ACC_W (ACC_W), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr),
    .wr_x (wr_x), .wr_w (wr_w), .go (go), .busy (busy), .result (result),
    .result_valid (result_valid), .timeout_err (timeout_err),
    .n_start (n_start), .n_x (n_x), .n_w (n_w), .n_done (n_done), .n_acc (n_acc)
  );

  // ---------------- neuron stub (observes mid-cycle, on negedge) ----------
  int stub_mode  = 0;   // 0: answers, 1: never answers
  int stub_delay = 0;   // extra WAIT cycles before n_done
  logic spur = 1'b0;    // force n_done high regardless of state
  bit st_armed = 0, st_pending = 0;
  int st_cnt = 0, st_acc = 0, st_pend = 0;

  always @(negedge clk) begin
    n_done = 1'b0;
    if (rst) begin
      st_armed   = 0;
      st_pending = 0;
    end else if (spur) begin
      n_done = 1'b1;
      n_acc  = 16'h1234;
    end else begin
      if (st_pending) begin
        if (st_pend == 0) begin
          n_done     = (stub_mode == 0);
          n_acc      = ACC_W'(st_acc);
          st_pending = 0;
        end else begin
          st_pend--;
        end
      end
      if (n_start) begin
        st_armed = 1; st_cnt = 0; st_acc = 0;
      end else if (st_armed) begin
        st_cnt++;
        if (st_cnt >= 2) begin
          st_acc += int'($signed(n_x)) * int'($signed(n_w));
          if (st_cnt == N_TAPS + 1) begin
            st_armed = 0; st_pending = 1; st_pend = stub_delay;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- helpers ----------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ACC_W-1:0] exp_result();
    int s = 0;
    for (int i = 0; i < N_TAPS; i++)
      s += int'($signed(mbank[i].x)) * int'($signed(mbank[i].w));
    return ACC_W'(s);
  endfunction

  task automatic wr(input int a, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] w);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_x = x; wr_w = w;
    if (a < N_TAPS) begin mbank[a].x = x; mbank[a].w = w; end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_basic();
    wr(0, 8'd2, 8'd5); wr(1, 8'd3, 8'd6); wr(2, 8'd4, 8'd7);
  endtask

  // Drives one evaluation from IDLE and checks the cycle schedule.
  task automatic run_go(input string name, input int delay, input bit with_wr,
                        input int a, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] w);
    logic [ACC_W-1:0] exp;
    int lat;
    bit got;
    stub_mode = 0;
    stub_delay = delay;
    go = 1'b1;
    if (with_wr) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_x = x; wr_w = w;
      if (a < N_TAPS) begin mbank[a].x = x; mbank[a].w = w; end
    end
    exp = exp_result();
    tick();
    go = 1'b0; wr_en = 1'b0;
    checks++;
    if (n_start !== 1'b1 || busy !== 1'b1 || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL %s start: n_start=%b busy=%b timeout_err=%b, want 1 1 0", name, n_start, busy, timeout_err);
    end
    tick();
    checks++;
    if (n_start !== 1'b0 || busy !== 1'b1 || n_x !== '0 || n_w !== '0) begin
      failures++;
      $display("FAIL %s gap: n_start=%b busy=%b n_x=%h n_w=%h, want 0 1 00 00", name, n_start, busy, n_x, n_w);
    end
    for (int i = 0; i < N_TAPS; i++) begin
      tick();
      checks++;
      if (n_x !== mbank[i].x || n_w !== mbank[i].w || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s tap%0d: n_x=%h n_w=%h busy=%b, want %h %h 1", name, i, n_x, n_w, busy, mbank[i].x, mbank[i].w);
      end
    end
    lat = N_TAPS + 2;
    got = 0;
    while (!got && lat < N_TAPS + 6 + TIMEOUT) begin
      tick();
      lat++;
      if (result_valid === 1'b1) got = 1;
    end
    checks++;
    if (!got || lat != N_TAPS + 4 + delay || result !== exp || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s result: got_valid=%0d latency=%0d result=%h busy=%b, want 1 %0d %h 0",
               name, got, lat, result, busy, N_TAPS + 4 + delay, exp);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      failures++;
      $display("FAIL %s after: result_valid=%b busy=%b result=%h, want 0 0 %h", name, result_valid, busy, result, exp);
    end
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    for (int i = 0; i < N_TAPS; i++) mbank[i] = '0;
    #12;
    checks++;
    if (busy !== 0 || n_start !== 0 || result_valid !== 0 || timeout_err !== 0 ||
        n_x !== '0 || n_w !== '0 || result !== '0) begin
      failures++;
      $display("FAIL reset: busy=%b n_start=%b rv=%b to=%b n_x=%h n_w=%h result=%h, want all 0",
               busy, n_start, result_valid, timeout_err, n_x, n_w, result);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load_basic();
    run_go("basic", 0, 0, 0, '0, '0);
    checks++;
    if (result !== 16'd56) begin
      failures++;
      $display("FAIL basic_value: result=%h, want 0038", result);
    end
  endtask

  task automatic test_signed();
    wr(0, 8'hFD, 8'd4); wr(1, 8'd5, 8'hFE); wr(2, 8'hFF, 8'hFF);
    run_go("signed", 1, 0, 0, '0, '0);
    checks++;
    if (result !== 16'hFFEB) begin
      failures++;
      $display("FAIL signed_value: result=%h, want ffeb", result);
    end
  endtask

  task automatic test_busy_ignore();
    int starts = 0, valids = 0;
    bit done = 0;
    logic [ACC_W-1:0] exp;
    load_basic();
    exp = exp_result();
    stub_mode = 0; stub_delay = 2;
    go = 1'b1;
    tick();
    for (int c = 0; c < 60 && !done; c++) begin
      if (n_start === 1'b1) starts++;
      if (result_valid === 1'b1) valids++;
      if (busy === 1'b1) begin
        go = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_x = 8'd9; wr_w = 8'd9;
      end else begin
        go = 1'b0; wr_en = 1'b0;
        done = 1;
      end
      if (!done) tick();
    end
    checks++;
    if (!done || starts != 1 || valids != 1 || result !== exp) begin
      failures++;
      $display("FAIL busy_ignore: done=%0d starts=%0d valids=%0d result=%h, want 1 1 1 %h",
               done, starts, valids, result, exp);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || n_start !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore_idle: busy=%b n_start=%b, want 0 0", busy, n_start);
    end
    run_go("busy_ignore_rerun", 0, 0, 0, '0, '0);
  endtask

  task automatic test_timeout();
    logic [ACC_W-1:0] prior;
    int nb = 0;
    bit seen_v = 0;
    prior = result;
    stub_mode = 1;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (result_valid === 1'b1) seen_v = 1;
      if (busy !== 1'b1) break;
      nb++;
      tick();
    end
    checks++;
    if (nb != N_TAPS + 2 + TIMEOUT || timeout_err !== 1'b1 || result !== prior || seen_v) begin
      failures++;
      $display("FAIL timeout: busy_cycles=%0d timeout_err=%b result=%h valid_seen=%0d, want %0d 1 %h 0",
               nb, timeout_err, result, seen_v, N_TAPS + 2 + TIMEOUT, prior);
    end
    tick(); tick();
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: timeout_err=%b, want 1", timeout_err);
    end
    run_go("timeout_clear", 0, 0, 0, '0, '0);
  endtask

  task automatic test_spurious_done();
    logic [ACC_W-1:0] prior;
    bit bad = 0;
    prior = result;
    spur = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (result_valid !== 1'b0 || result !== prior || busy !== 1'b0) bad = 1;
    end
    spur = 1'b0;
    tick();
    checks++;
    if (bad || result !== prior) begin
      failures++;
      $display("FAIL spurious_done: reacted=%0d result=%h, want 0 %h", bad, result, prior);
    end
  endtask

  task automatic test_reset_mid_feed();
    load_basic();
    stub_mode = 0; stub_delay = 0;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick(); tick();   // START -> GAP -> tap0 -> tap1
    checks++;
    if (n_x !== mbank[1].x || n_w !== mbank[1].w) begin
      failures++;
      $display("FAIL reset_pre_tap1: n_x=%h n_w=%h, want %h %h", n_x, n_w, mbank[1].x, mbank[1].w);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 0 || n_start !== 0 || result_valid !== 0 || timeout_err !== 0 ||
        n_x !== '0 || n_w !== '0 || result !== '0) begin
      failures++;
      $display("FAIL reset_mid_feed: busy=%b n_start=%b rv=%b to=%b n_x=%h n_w=%h result=%h, want all 0",
               busy, n_start, result_valid, timeout_err, n_x, n_w, result);
    end
    for (int i = 0; i < N_TAPS; i++) mbank[i] = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    run_go("after_reset", 0, 0, 0, '0, '0);
  endtask

  task automatic test_wr_go_same_cycle();
    wr(0, 8'd2, 8'd5); wr(1, 8'd3, 8'd6); wr(2, 8'd1, 8'd1);
    run_go("wr_go", 0, 1, 2, 8'd10, 8'd10);
    checks++;
    if (result !== 16'd128) begin
      failures++;
      $display("FAIL wr_go_value: result=%h, want 0080", result);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int j = 0; j < nw; j++)
        wr($urandom_range(0, 3), DATA_W'($urandom), DATA_W'($urandom));
      run_go("random", $urandom_range(0, 5), 0, 0, '0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_busy_ignore();
    test_timeout();
    test_spurious_done();
    test_reset_mid_feed();
    test_wr_go_same_cycle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
